// File: rtl/pwm_pkg.sv
// Shared widths and ramp state encoding for the PWM configuration sequencer.
package pwm_pkg;

  localparam int unsigned PWM_DW = 32;
  localparam int unsigned PWM_SW = 16;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_duty_ramp.sv
// Duty ramp engine: holds active duty, target and step, and steps the duty
// toward the target once per PWM period.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned DW = PWM_DW,
  parameter int unsigned SW = PWM_SW
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pe,
  input  logic          commit,
  input  logic [DW-1:0] sh_freq,
  input  logic [DW-1:0] sh_duty,
  input  logic [SW-1:0] sh_step,
  output logic [DW-1:0] duty,
  output logic          ramping
);

  logic [1:0]    state_raw;
  ramp_state_t   state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] target_q, target_d;
  logic [SW-1:0] step_q, step_d;

  logic [DW:0]   freq_p1;
  logic [DW-1:0] clamp;
  logic [DW-1:0] step_ext;
  logic [DW-1:0] diff;
  logic          up;

  assign state_q = ramp_state_t'(state_raw);

  yj_basic_reg_clk_p #(.DW(2), .RST_VAL(ST_OFF)) u_state_reg (
    .CLK(CLK), .RSTn(rst_n), .din(state_d), .qout(state_raw)
  );
  yj_basic_reg_clk_p #(.DW(DW), .RST_VAL('0)) u_duty_reg (
    .CLK(CLK), .RSTn(rst_n), .din(duty_d), .qout(duty_q)
  );
  yj_basic_reg_clk_p #(.DW(DW), .RST_VAL('0)) u_target_reg (
    .CLK(CLK), .RSTn(rst_n), .din(target_d), .qout(target_q)
  );
  yj_basic_reg_clk_p #(.DW(SW), .RST_VAL('0)) u_step_reg (
    .CLK(CLK), .RSTn(rst_n), .din(step_d), .qout(step_q)
  );

  // Target/step capture at commit; target is clamped to 100% (period+1).
  always_comb begin
    freq_p1  = {1'b0, sh_freq} + (DW+1)'(1);
    clamp    = ({1'b0, sh_duty} <= freq_p1) ? sh_duty : freq_p1[DW-1:0];
    target_d = commit ? clamp   : target_q;
    step_d   = commit ? sh_step : step_q;
  end

  // Next-state and next-duty: enable=0 overrides everything, otherwise the
  // duty only moves at a period boundary that carries no commit.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    step_ext = {{(DW-SW){1'b0}}, step_q};
    up       = (target_q >= duty_q);
    diff     = up ? (target_q - duty_q) : (duty_q - target_q);
    if (!enable) begin
      state_d = ST_OFF;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          duty_d  = '0;
          state_d = ST_RAMP;
        end
        ST_RAMP: begin
          if (pe && !commit) begin
            if ((step_q == '0) || (diff <= step_ext)) begin
              duty_d  = target_q;
              state_d = ST_HOLD;
            end else begin
              duty_d = up ? (duty_q + step_ext) : (duty_q - step_ext);
            end
          end
        end
        ST_HOLD: begin
          if (commit) state_d = ST_RAMP;
        end
        default: begin
          state_d = ST_OFF;
          duty_d  = '0;
        end
      endcase
    end
  end

  assign duty    = duty_q;
  assign ramping = (state_q == ST_RAMP);

endmodule

// File: rtl/yj_basic_reg_clk_p.sv
// Basic rising-edge register with a synchronous active-low reset to RST_VAL.
module yj_basic_reg_clk_p #(
  parameter int unsigned     DW      = 1,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] qout
);

  // Load din every cycle; RSTn is sampled on the clock edge.
  always_ff @(posedge CLK) begin
    if (!RSTn) qout <= RST_VAL;
    else       qout <= din;
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Configuration sequencer for one PWM channel: shadow-buffered handshake,
// period-aligned commit and soft duty ramping.
module pwm_seq_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned   DW       = PWM_DW,
  parameter int unsigned   SW       = PWM_SW,
  parameter logic [DW-1:0] FREQ_RST = 32'd999
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_freq,
  input  logic [DW-1:0] cfg_duty,
  input  logic [SW-1:0] cfg_step,
  output logic [DW-1:0] FREQ_Cnt_Set,
  output logic [DW-1:0] Chn_duty_Set,
  output logic          period_tick,
  output logic          busy
);

  logic          rst_n;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] freq_q, freq_d;
  logic [DW-1:0] sh_freq_q, sh_freq_d;
  logic [DW-1:0] sh_duty_q, sh_duty_d;
  logic [SW-1:0] sh_step_q, sh_step_d;
  logic          pend_q, pend_d;
  logic          pe, accept, commit;
  logic          ramping;

  // RST is synchronous, so an inverted copy is a clean register reset.
  assign rst_n = ~RST;

  yj_basic_reg_clk_p #(.DW(DW), .RST_VAL('0)) u_cnt_reg (
    .CLK(CLK), .RSTn(rst_n), .din(cnt_d), .qout(cnt_q)
  );
  yj_basic_reg_clk_p #(.DW(DW), .RST_VAL(FREQ_RST)) u_freq_reg (
    .CLK(CLK), .RSTn(rst_n), .din(freq_d), .qout(freq_q)
  );
  yj_basic_reg_clk_p #(.DW(DW), .RST_VAL('0)) u_sh_freq_reg (
    .CLK(CLK), .RSTn(rst_n), .din(sh_freq_d), .qout(sh_freq_q)
  );
  yj_basic_reg_clk_p #(.DW(DW), .RST_VAL('0)) u_sh_duty_reg (
    .CLK(CLK), .RSTn(rst_n), .din(sh_duty_d), .qout(sh_duty_q)
  );
  yj_basic_reg_clk_p #(.DW(SW), .RST_VAL('0)) u_sh_step_reg (
    .CLK(CLK), .RSTn(rst_n), .din(sh_step_d), .qout(sh_step_q)
  );
  yj_basic_reg_clk_p #(.DW(1), .RST_VAL(1'b0)) u_pend_reg (
    .CLK(CLK), .RSTn(rst_n), .din(pend_d), .qout(pend_q)
  );

  // Lock-step period counter, shadow capture and commit control.
  // Accept and commit are exclusive because ready is low while pending.
  always_comb begin
    pe        = (cnt_q == freq_q);
    commit    = pe & pend_q;
    accept    = cfg_valid & ~pend_q;
    cnt_d     = pe ? '0 : (cnt_q + DW'(1));
    freq_d    = commit ? sh_freq_q : freq_q;
    sh_freq_d = accept ? cfg_freq : sh_freq_q;
    sh_duty_d = accept ? cfg_duty : sh_duty_q;
    sh_step_d = accept ? cfg_step : sh_step_q;
    pend_d    = pend_q;
    if (commit)      pend_d = 1'b0;
    else if (accept) pend_d = 1'b1;
  end

  pwm_duty_ramp #(.DW(DW), .SW(SW)) u_ramp (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .enable (enable),
    .pe     (pe),
    .commit (commit),
    .sh_freq(sh_freq_q),
    .sh_duty(sh_duty_q),
    .sh_step(sh_step_q),
    .duty   (Chn_duty_Set),
    .ramping(ramping)
  );

  assign cfg_ready    = ~pend_q;
  assign FREQ_Cnt_Set = freq_q;
  assign period_tick  = pe;
  assign busy         = pend_q | ramping;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed testbench for pwm_seq_ctrl with a reference PWM period counter.
module tb_pwm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_freq;
  logic [31:0] cfg_duty;
  logic [15:0] cfg_step;
  logic [31:0] freq_set;
  logic [31:0] duty_set;
  logic        period_tick;
  logic        busy;

  logic [31:0] pwm_cnt;
  int checks = 0;
  int errors = 0;

  pwm_seq_ctrl #(.DW(32), .SW(16), .FREQ_RST(32'd999)) dut (
    .CLK         (clk),
    .RST         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_freq    (cfg_freq),
    .cfg_duty    (cfg_duty),
    .cfg_step    (cfg_step),
    .FREQ_Cnt_Set(freq_set),
    .Chn_duty_Set(duty_set),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference perip_PWM period counter, reset through the inverted RST.
  always @(posedge clk) begin
    if (rst) pwm_cnt <= 32'd0;
    else     pwm_cnt <= (pwm_cnt == freq_set) ? 32'd0 : pwm_cnt + 32'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 3000);
    if (!period_tick) begin
      checks++; errors++;
      $display("FAIL tick_timeout got no period_tick in %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_freq = '0; cfg_duty = '0; cfg_step = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (freq_set !== 32'd999) begin errors++; $display("FAIL rst_freq got %0d want 999", freq_set); end
    checks++; if (duty_set !== 32'd0) begin errors++; $display("FAIL rst_duty got %0d want 0", duty_set); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", period_tick); end
    wait_tick(n);
    checks++; if (n != 999) begin errors++; $display("FAIL rst_first_tick got %0d want 999", n); end
  endtask

  task automatic test_direct_jump();
    int n;
    int hi;
    enable = 1'b1; cfg_valid = 1'b1;
    cfg_freq = 32'd9; cfg_duty = 32'd4; cfg_step = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL jump_ready_low got %b want 0", cfg_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL jump_busy_pend got %b want 1", busy); end
    wait_tick(n);
    checks++; if (n != 999) begin errors++; $display("FAIL jump_wait got %0d want 999", n); end
    @(negedge clk);
    checks++; if (freq_set !== 32'd9) begin errors++; $display("FAIL jump_freq got %0d want 9", freq_set); end
    checks++; if (duty_set !== 32'd0) begin errors++; $display("FAIL jump_duty_commit got %0d want 0", duty_set); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL jump_ready_back got %b want 1", cfg_ready); end
    checks++; if (pwm_cnt !== 32'd0 || period_tick !== 1'b0) begin errors++; $display("FAIL jump_align got pwm_cnt=%0d tick=%b want 0 0", pwm_cnt, period_tick); end
    wait_tick(n);
    checks++; if (n != 9) begin errors++; $display("FAIL jump_period got %0d want 9", n); end
    @(negedge clk);
    checks++; if (duty_set !== 32'd4) begin errors++; $display("FAIL jump_duty got %0d want 4", duty_set); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL jump_busy_done got %b want 0", busy); end
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (pwm_cnt < duty_set) hi++;
      @(negedge clk);
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL jump_high_cycles got %0d want 4", hi); end
  endtask

  task automatic test_ramp();
    int n;
    logic [31:0] up_exp [3];
    logic [31:0] dn_exp [3];
    up_exp = '{32'd3, 32'd6, 32'd8};
    dn_exp = '{32'd5, 32'd2, 32'd1};
    enable = 1'b0;
    @(negedge clk);
    checks++; if (duty_set !== 32'd0) begin errors++; $display("FAIL ramp_off_duty got %0d want 0", duty_set); end
    cfg_valid = 1'b1; cfg_freq = 32'd9; cfg_duty = 32'd8; cfg_step = 16'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(n);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || duty_set !== 32'd0) begin errors++; $display("FAIL ramp_commit_off got busy=%b duty=%0d want 0 0", busy, duty_set); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      @(negedge clk);
      checks++; if (duty_set !== up_exp[i]) begin errors++; $display("FAIL ramp_up_%0d got %0d want %0d", i, duty_set, up_exp[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_up_hold got busy=%b want 0", busy); end
    cfg_valid = 1'b1; cfg_freq = 32'd9; cfg_duty = 32'd1; cfg_step = 16'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(n);
    @(negedge clk);
    checks++; if (duty_set !== 32'd8 || busy !== 1'b1) begin errors++; $display("FAIL ramp_dn_commit got duty=%0d busy=%b want 8 1", duty_set, busy); end
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      @(negedge clk);
      checks++; if (duty_set !== dn_exp[i]) begin errors++; $display("FAIL ramp_dn_%0d got %0d want %0d", i, duty_set, dn_exp[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_dn_hold got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_valid = 1'b1; cfg_freq = 32'd7; cfg_duty = 32'd2; cfg_step = 16'd0;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready1 got %b want 0", cfg_ready); end
    cfg_freq = 32'd4; cfg_duty = 32'd3; cfg_step = 16'd0;
    wait_tick(n);
    checks++; if (cfg_ready !== 1'b0 || freq_set !== 32'd9) begin errors++; $display("FAIL b2b_stall got ready=%b freq=%0d want 0 9", cfg_ready, freq_set); end
    @(negedge clk);
    checks++; if (freq_set !== 32'd7 || cfg_ready !== 1'b1 || duty_set !== 32'd1) begin errors++; $display("FAIL b2b_commit1 got freq=%0d ready=%b duty=%0d want 7 1 1", freq_set, cfg_ready, duty_set); end
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2 got %b want 0", cfg_ready); end
    cfg_valid = 1'b0;
    wait_tick(n);
    checks++; if (n != 6) begin errors++; $display("FAIL b2b_period7 got %0d want 6", n); end
    @(negedge clk);
    checks++; if (freq_set !== 32'd4 || duty_set !== 32'd1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_commit2 got freq=%0d duty=%0d busy=%b want 4 1 1", freq_set, duty_set, busy); end
    wait_tick(n);
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_period4 got %0d want 4", n); end
    @(negedge clk);
    checks++; if (duty_set !== 32'd3 || busy !== 1'b0) begin errors++; $display("FAIL b2b_duty got duty=%0d busy=%b want 3 0", duty_set, busy); end
  endtask

  task automatic test_clamp_enable_off();
    int n;
    cfg_valid = 1'b1; cfg_freq = 32'd9; cfg_duty = 32'd50; cfg_step = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(n);
    @(negedge clk);
    checks++; if (freq_set !== 32'd9 || duty_set !== 32'd3) begin errors++; $display("FAIL clamp_commit got freq=%0d duty=%0d want 9 3", freq_set, duty_set); end
    wait_tick(n);
    @(negedge clk);
    checks++; if (duty_set !== 32'd10) begin errors++; $display("FAIL clamp_duty got %0d want 10", duty_set); end
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (duty_set !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL enoff_duty got duty=%0d busy=%b want 0 0", duty_set, busy); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (duty_set !== 32'd0 || busy !== 1'b1) begin errors++; $display("FAIL reen_wait got duty=%0d busy=%b want 0 1", duty_set, busy); end
    wait_tick(n);
    @(negedge clk);
    checks++; if (duty_set !== 32'd10) begin errors++; $display("FAIL reen_duty got %0d want 10", duty_set); end
  endtask

  task automatic test_period_change();
    int last;
    last = -1;
    cfg_valid = 1'b1; cfg_freq = 32'd4; cfg_duty = 32'd2; cfg_step = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (period_tick !== (pwm_cnt == freq_set)) begin
        errors++; $display("FAIL pc_lockstep_%0d got tick=%b pwm_cnt=%0d freq=%0d", i, period_tick, pwm_cnt, freq_set);
      end
      if (period_tick) begin
        if (last >= 0) begin
          checks++; if (i - last != 5) begin errors++; $display("FAIL pc_spacing got %0d want 5", i - last); end
        end
        last = i;
      end
      @(negedge clk);
    end
    checks++; if (freq_set !== 32'd4 || duty_set !== 32'd2) begin errors++; $display("FAIL pc_final got freq=%0d duty=%0d want 4 2", freq_set, duty_set); end
  endtask

  task automatic test_reset_midflight();
    int n;
    cfg_valid = 1'b1; cfg_freq = 32'd9; cfg_duty = 32'd5; cfg_step = 16'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pend got %b want 0", cfg_ready); end
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (freq_set !== 32'd999 || duty_set !== 32'd0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst got freq=%0d duty=%0d ready=%b busy=%b want 999 0 1 0", freq_set, duty_set, cfg_ready, busy);
    end
    wait_tick(n);
    @(negedge clk);
    checks++; if (freq_set !== 32'd999) begin errors++; $display("FAIL mid_discard got freq=%0d want 999", freq_set); end
  endtask

  initial begin
    test_reset();
    test_direct_jump();
    test_ramp();
    test_back_to_back();
    test_clamp_enable_off();
    test_period_change();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
